imem_responder: RTL and testbench

Instruction-memory responder serving the fetch stage's `ImemAddr` request and returning `ImemDataR`. It wraps a word-addressed synchronous-read RAM with a configurable read latency. A one-entry tag register holds the last fetched word, and a fetch stall is raised whenever the presented PC is not the tagged one. A boot loader write port fills the RAM before and between runs. The block sits between the IF stage and the instruction RAM, and its stall output feeds the pipeline stall network.

---
 rtl/imem_responder_pkg.sv | 18 +
 rtl/imem_responder_if.sv | 25 ++
 rtl/imem_ram.sv | 46 ++++
 rtl/imem_responder.sv | 152 +++++++++++++++
 tb/tb_imem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  // Word returned after reset and for out-of-range or misaligned fetches.
  localparam logic [WORD_W-1:0] IMEM_NOP_WORD   = 32'h0000_0000;
  // Fetch start address; fetch and the responder must agree on it.
  localparam logic [WORD_W-1:0] MIPS_START_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch and boot-loader signal bundle between the IF stage and the responder.
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic [WORD_W-1:0] i_IF_mem_ImemAddr;
  logic [WORD_W-1:0] o_IF_mem_ImemDataR;
  logic              o_IF_stall;
  logic              i_LD_valid;
  logic [WORD_W-1:0] i_LD_addr;
  logic [WORD_W-1:0] i_LD_data;
  logic              o_LD_ready;
  logic              o_err;

  // Fetch stage / boot loader side.
  modport master (
    output i_IF_mem_ImemAddr, i_LD_valid, i_LD_addr, i_LD_data,
    input  o_IF_mem_ImemDataR, o_IF_stall, o_LD_ready, o_err
  );

  // Responder side.
  modport slave (
    input  i_IF_mem_ImemAddr, i_LD_valid, i_LD_addr, i_LD_data,
    output o_IF_mem_ImemDataR, o_IF_stall, o_LD_ready, o_err
  );
endinterface

// File: rtl/imem_ram.sv
// Single-port word RAM: sync write, sync read, then WAIT_CYCLES-1 output stages.
module imem_ram
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned LAST = WAIT_CYCLES - 1;

  logic [WORD_W-1:0] mem_q  [DEPTH_WORDS];
  logic [WORD_W-1:0] pipe_q [WAIT_CYCLES];
  logic [WORD_W-1:0] pipe_d [WAIT_CYCLES];

  // Stage 0 is the synchronous read; later stages only add latency.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = re ? mem_q[addr] : pipe_q[0];
    for (int i = 1; i < int'(WAIT_CYCLES); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Storage array; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read pipeline advance.
  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
  end

  assign rdata = pipe_q[LAST];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one-entry tag in front of a latency-configurable RAM,
// with a boot-loader write port that has priority over new fetches.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [WORD_W-1:0] BASE_ADDR   = MIPS_START_ADDR,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [WORD_W-1:0] NOP_WORD    = IMEM_NOP_WORD
) (
  input logic             clk,
  input logic             rst,
  imem_responder_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RANGE_LIM = 33'(DEPTH_WORDS) << 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tag_valid_q, tag_valid_d;
  logic [WORD_W-1:0] tag_addr_q, tag_addr_d;
  logic [WORD_W-1:0] tag_data_q, tag_data_d;
  logic [WORD_W-1:0] req_addr_q, req_addr_d;
  logic              req_in_range_q, req_in_range_d;
  logic              err_q, err_d;
  logic              ld_ready_q, ld_ready_d;

  logic [WORD_W-1:0] fetch_off, ld_off;
  logic              fetch_in_range, ld_in_range;
  logic [AW-1:0]     ram_addr;
  logic              ram_we, ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic              hit;

  // Address decode for both requesters (unsigned offset from BASE_ADDR).
  always_comb begin
    fetch_off      = bus.i_IF_mem_ImemAddr - BASE_ADDR;
    ld_off         = bus.i_LD_addr - BASE_ADDR;
    fetch_in_range = (bus.i_IF_mem_ImemAddr[1:0] == 2'b00) && ({1'b0, fetch_off} < RANGE_LIM);
    ld_in_range    = (bus.i_LD_addr[1:0] == 2'b00) && ({1'b0, ld_off} < RANGE_LIM);
    hit            = tag_valid_q && (tag_addr_q == bus.i_IF_mem_ImemAddr) && (state_q == ST_IDLE);
  end

  // Next-state, tag update and RAM control.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tag_valid_d    = tag_valid_q;
    tag_addr_d     = tag_addr_q;
    tag_data_d     = tag_data_q;
    req_addr_d     = req_addr_q;
    req_in_range_d = req_in_range_q;
    err_d          = err_q;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    ram_addr       = fetch_off[AW+1:2];

    case (state_q)
      ST_IDLE: begin
        if (bus.i_LD_valid) begin
          state_d = ST_LOAD;
        end else if (!hit) begin
          req_addr_d     = bus.i_IF_mem_ImemAddr;
          req_in_range_d = fetch_in_range;
          ram_re         = 1'b1;
          cnt_d          = CNT_W'(WAIT_CYCLES - 1);
          state_d        = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          tag_data_d  = req_in_range_q ? ram_rdata : NOP_WORD;
          tag_addr_d  = req_addr_q;
          tag_valid_d = 1'b1;
          if (!req_in_range_q) begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_LOAD: begin
        ram_addr = ld_off[AW+1:2];
        if (bus.i_LD_valid) begin
          if (ld_in_range) begin
            ram_we = 1'b1;
            // BASE_ADDR is word aligned, so equal word addresses mean equal indices.
            if (bus.i_LD_addr[31:2] == tag_addr_q[31:2]) begin
              tag_valid_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ld_ready_d = (state_d == ST_LOAD);
  end

  // State, tag and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tag_valid_q    <= 1'b0;
      tag_addr_q     <= '0;
      tag_data_q     <= NOP_WORD;
      req_addr_q     <= '0;
      req_in_range_q <= 1'b0;
      err_q          <= 1'b0;
      ld_ready_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tag_valid_q    <= tag_valid_d;
      tag_addr_q     <= tag_addr_d;
      tag_data_q     <= tag_data_d;
      req_addr_q     <= req_addr_d;
      req_in_range_q <= req_in_range_d;
      err_q          <= err_d;
      ld_ready_q     <= ld_ready_d;
    end
  end

  imem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (bus.i_LD_data),
    .rdata (ram_rdata)
  );

  assign bus.o_IF_mem_ImemDataR = tag_data_q;
  assign bus.o_IF_stall         = !hit;
  assign bus.o_LD_ready         = ld_ready_q;
  assign bus.o_err              = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: dut1 has a 1-cycle RAM, dut3 a 3-cycle RAM.
module tb_imem_responder;

  localparam logic [31:0] NOP1 = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP3 = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   total = 0;
  int   bad   = 0;

  imem_responder_if b1();
  imem_responder_if b3();

  imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1), .NOP_WORD(NOP1))
    dut1 (.clk(clk), .rst(rst1), .bus(b1));
  imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3), .NOP_WORD(NOP3))
    dut3 (.clk(clk), .rst(rst3), .bus(b3));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Miss on dut1 (latency 1): two stall cycles, then data, then a held hit.
  task automatic fetch_seq(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    b1.i_IF_mem_ImemAddr = addr;
    #1;
    total++; if (b1.o_IF_stall !== 1'b1) begin bad++; $display("FAIL miss_stall addr=%h got=%b exp=1", addr, b1.o_IF_stall); end
    total++; if (b1.o_LD_ready !== 1'b0) begin bad++; $display("FAIL ready_idle addr=%h got=%b exp=0", addr, b1.o_LD_ready); end
    step;
    total++; if (b1.o_IF_stall !== 1'b1) begin bad++; $display("FAIL wait_stall addr=%h got=%b exp=1", addr, b1.o_IF_stall); end
    step;
    total++; if (b1.o_IF_stall !== 1'b0) begin bad++; $display("FAIL done_stall addr=%h got=%b exp=0", addr, b1.o_IF_stall); end
    total++; if (b1.o_IF_mem_ImemDataR !== exp_data) begin bad++; $display("FAIL fetch_data addr=%h got=%h exp=%h", addr, b1.o_IF_mem_ImemDataR, exp_data); end
    total++; if (b1.o_err !== exp_err) begin bad++; $display("FAIL fetch_err addr=%h got=%b exp=%b", addr, b1.o_err, exp_err); end
    step;
    total++; if (b1.o_IF_stall !== 1'b0 || b1.o_IF_mem_ImemDataR !== exp_data) begin bad++; $display("FAIL hold_hit addr=%h stall=%b data=%h exp stall=0 data=%h", addr, b1.o_IF_stall, b1.o_IF_mem_ImemDataR, exp_data); end
    step;
  endtask

  // Loader burst of n consecutive words on dut1, starting from IDLE.
  task automatic ld_seq(input int n, input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    b1.i_LD_valid = 1'b1;
    b1.i_LD_addr  = base;
    b1.i_LD_data  = d[0];
    #1;
    total++; if (b1.o_LD_ready !== 1'b0) begin bad++; $display("FAIL ld_entry_ready got=%b exp=0", b1.o_LD_ready); end
    step;
    for (int i = 0; i < n; i++) begin
      b1.i_LD_addr = base + 32'(4 * i);
      b1.i_LD_data = d[i];
      #1;
      total++; if (b1.o_LD_ready !== 1'b1) begin bad++; $display("FAIL ld_beat_ready beat=%0d got=%b exp=1", i, b1.o_LD_ready); end
      total++; if (b1.o_IF_stall !== 1'b1) begin bad++; $display("FAIL ld_beat_stall beat=%0d got=%b exp=1", i, b1.o_IF_stall); end
      step;
    end
    b1.i_LD_valid = 1'b0;
    #1;
    total++; if (b1.o_LD_ready !== 1'b1) begin bad++; $display("FAIL ld_exit_ready got=%b exp=1", b1.o_LD_ready); end
    step;
  endtask

  // One reset cycle on dut1; returns in the first post-reset cycle with rst released.
  task automatic do_reset1;
    rst1 = 1'b1;
    b1.i_LD_valid = 1'b0;
    step;
    total++; if (b1.o_IF_stall !== 1'b1) begin bad++; $display("FAIL rst1_stall got=%b exp=1", b1.o_IF_stall); end
    total++; if (b1.o_IF_mem_ImemDataR !== NOP1) begin bad++; $display("FAIL rst1_data got=%h exp=%h", b1.o_IF_mem_ImemDataR, NOP1); end
    total++; if (b1.o_err !== 1'b0) begin bad++; $display("FAIL rst1_err got=%b exp=0", b1.o_err); end
    total++; if (b1.o_LD_ready !== 1'b0) begin bad++; $display("FAIL rst1_ready got=%b exp=0", b1.o_LD_ready); end
    rst1 = 1'b0;
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst3 = 1'b1;
    b1.i_IF_mem_ImemAddr = '0; b1.i_LD_valid = 1'b0; b1.i_LD_addr = '0; b1.i_LD_data = '0;
    b3.i_IF_mem_ImemAddr = '0; b3.i_LD_valid = 1'b0; b3.i_LD_addr = '0; b3.i_LD_data = '0;
    step;
    step;
    total++; if (b1.o_IF_stall !== 1'b1) begin bad++; $display("FAIL reset_stall1 got=%b exp=1", b1.o_IF_stall); end
    total++; if (b1.o_IF_mem_ImemDataR !== NOP1) begin bad++; $display("FAIL reset_data1 got=%h exp=%h", b1.o_IF_mem_ImemDataR, NOP1); end
    total++; if (b1.o_err !== 1'b0) begin bad++; $display("FAIL reset_err1 got=%b exp=0", b1.o_err); end
    total++; if (b1.o_LD_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b exp=0", b1.o_LD_ready); end
    total++; if (b3.o_IF_stall !== 1'b1) begin bad++; $display("FAIL reset_stall3 got=%b exp=1", b3.o_IF_stall); end
    total++; if (b3.o_IF_mem_ImemDataR !== NOP3) begin bad++; $display("FAIL reset_data3 got=%h exp=%h", b3.o_IF_mem_ImemDataR, NOP3); end
    total++; if (b3.o_err !== 1'b0 || b3.o_LD_ready !== 1'b0) begin bad++; $display("FAIL reset_flags3 err=%b ready=%b exp 0 0", b3.o_err, b3.o_LD_ready); end
    rst1 = 1'b0;
  endtask

  task automatic test_first_fetch;
    ld_seq(1, 32'h0, 32'h2008_0005, 32'h0, 32'h0, 32'h0);
    do_reset1();
    fetch_seq(32'h0, 32'h2008_0005, 1'b0);
  endtask

  task automatic test_load_fetch;
    ld_seq(4, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    fetch_seq(32'h0, 32'h1111_1111, 1'b0);
    fetch_seq(32'h4, 32'h2222_2222, 1'b0);
    fetch_seq(32'h8, 32'h3333_3333, 1'b0);
    fetch_seq(32'hC, 32'h4444_4444, 1'b0);
  endtask

  task automatic test_hit_reload;
    fetch_seq(32'h8, 32'h3333_3333, 1'b0);
    ld_seq(1, 32'h8, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    fetch_seq(32'h8, 32'hDEAD_BEEF, 1'b0);
    // A write elsewhere leaves the tag intact.
    ld_seq(1, 32'h10, 32'h5555_5555, 32'h0, 32'h0, 32'h0);
    total++; if (b1.o_IF_stall !== 1'b0 || b1.o_IF_mem_ImemDataR !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tag_kept stall=%b data=%h exp stall=0 data=deadbeef", b1.o_IF_stall, b1.o_IF_mem_ImemDataR); end
    step;
    // Loader request raised mid-fetch waits for the fetch to finish.
    b1.i_IF_mem_ImemAddr = 32'h4;
    step;
    b1.i_LD_valid = 1'b1; b1.i_LD_addr = 32'h20; b1.i_LD_data = 32'h6666_6666;
    #1;
    total++; if (b1.o_LD_ready !== 1'b0 || b1.o_IF_stall !== 1'b1) begin bad++; $display("FAIL ld_in_wait ready=%b stall=%b exp 0 1", b1.o_LD_ready, b1.o_IF_stall); end
    step;
    total++; if (b1.o_IF_stall !== 1'b0 || b1.o_IF_mem_ImemDataR !== 32'h2222_2222 || b1.o_LD_ready !== 1'b0) begin bad++; $display("FAIL fetch_before_ld stall=%b data=%h ready=%b exp 0 22222222 0", b1.o_IF_stall, b1.o_IF_mem_ImemDataR, b1.o_LD_ready); end
    step;
    total++; if (b1.o_LD_ready !== 1'b1) begin bad++; $display("FAIL ld_after_wait_ready got=%b exp=1", b1.o_LD_ready); end
    step;
    b1.i_LD_valid = 1'b0;
    #1;
    total++; if (b1.o_LD_ready !== 1'b1) begin bad++; $display("FAIL ld_after_wait_exit got=%b exp=1", b1.o_LD_ready); end
    step;
    total++; if (b1.o_IF_stall !== 1'b0 || b1.o_IF_mem_ImemDataR !== 32'h2222_2222) begin bad++; $display("FAIL tag4_kept stall=%b data=%h exp 0 22222222", b1.o_IF_stall, b1.o_IF_mem_ImemDataR); end
    step;
    fetch_seq(32'h20, 32'h6666_6666, 1'b0);
  endtask

  task automatic test_out_of_range;
    fetch_seq(32'h1000, NOP1, 1'b1);
    fetch_seq(32'h6, NOP1, 1'b1);
    fetch_seq(32'h4, 32'h2222_2222, 1'b1);
    do_reset1();
  endtask

  task automatic test_reset_mid_load;
    b1.i_LD_valid = 1'b1; b1.i_LD_addr = 32'h30; b1.i_LD_data = 32'h7777_7777;
    step;
    total++; if (b1.o_LD_ready !== 1'b1) begin bad++; $display("FAIL mid_load_ready got=%b exp=1", b1.o_LD_ready); end
    step;
    b1.i_LD_addr = 32'h34; b1.i_LD_data = 32'h8888_8888;
    rst1 = 1'b1;
    step;
    total++; if (b1.o_LD_ready !== 1'b0) begin bad++; $display("FAIL mid_load_rst_ready got=%b exp=0", b1.o_LD_ready); end
    total++; if (b1.o_IF_stall !== 1'b1) begin bad++; $display("FAIL mid_load_rst_stall got=%b exp=1", b1.o_IF_stall); end
    total++; if (b1.o_err !== 1'b0) begin bad++; $display("FAIL mid_load_rst_err got=%b exp=0", b1.o_err); end
    rst1 = 1'b0;
    b1.i_LD_valid = 1'b0;
    fetch_seq(32'h30, 32'h7777_7777, 1'b0);
    fetch_seq(32'h0, 32'h1111_1111, 1'b0);
  endtask

  task automatic test_addr_change;
    rst3 = 1'b0;
    b3.i_LD_valid = 1'b1; b3.i_LD_addr = 32'h4; b3.i_LD_data = 32'hAAAA_0004;
    step;
    total++; if (b3.o_LD_ready !== 1'b1) begin bad++; $display("FAIL w3_ld_ready got=%b exp=1", b3.o_LD_ready); end
    step;
    b3.i_LD_addr = 32'h40; b3.i_LD_data = 32'hBBBB_0040;
    step;
    b3.i_LD_valid = 1'b0;
    step;
    b3.i_IF_mem_ImemAddr = 32'h4;
    #1;
    total++; if (b3.o_IF_stall !== 1'b1) begin bad++; $display("FAIL w3_miss got=%b exp=1", b3.o_IF_stall); end
    step;
    b3.i_IF_mem_ImemAddr = 32'h40;
    for (int i = 1; i <= 3; i++) begin
      #1;
      total++; if (b3.o_IF_stall !== 1'b1) begin bad++; $display("FAIL w3_wait_stall cyc=%0d got=%b exp=1", i, b3.o_IF_stall); end
      step;
    end
    total++; if (b3.o_IF_stall !== 1'b1 || b3.o_IF_mem_ImemDataR !== 32'hAAAA_0004) begin bad++; $display("FAIL w3_first_done stall=%b data=%h exp 1 aaaa0004", b3.o_IF_stall, b3.o_IF_mem_ImemDataR); end
    step;
    for (int i = 1; i <= 3; i++) begin
      total++; if (b3.o_IF_stall !== 1'b1) begin bad++; $display("FAIL w3_second_stall cyc=%0d got=%b exp=1", i, b3.o_IF_stall); end
      step;
    end
    total++; if (b3.o_IF_stall !== 1'b0 || b3.o_IF_mem_ImemDataR !== 32'hBBBB_0040) begin bad++; $display("FAIL w3_second_done stall=%b data=%h exp 0 bbbb0040", b3.o_IF_stall, b3.o_IF_mem_ImemDataR); end
    total++; if (b3.o_err !== 1'b0) begin bad++; $display("FAIL w3_err got=%b exp=0", b3.o_err); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_load_fetch();
    test_hit_reload();
    test_out_of_range();
    test_reset_mid_load();
    test_addr_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
